// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage owning the data memory, with a stretched load latency and MEM/WB register.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [1:0]  OP_in,
  input  logic [2:0]  DR_in,
  input  logic [15:0] ALU_res,
  input  logic [15:0] ST_data,
  output logic        stall_out,
  output logic [1:0]  OP,
  output logic [2:0]  DR,
  output logic [15:0] wb_data
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] OP_NOP = 2'b00, OP_ALU = 2'b01, OP_LD = 2'b10, OP_ST = 2'b11;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        dr_lat_q, dr_lat_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        dr_q, dr_d;
  logic [15:0]       wb_q, wb_d;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] in_addr;
  logic [15:0]       rdata;
  logic              we, idle_act;
  assign in_addr  = ALU_res[ADDR_W-1:0];
  assign idle_act = state_q == IDLE && valid_in;
  // The read port follows the latched address while busy, so the value is sampled at the completing edge.
  assign rdata    = mem[state_q == BUSY ? addr_q : in_addr];
  assign stall_out = rst_n && ((idle_act && OP_in == OP_LD && MEM_LAT > 1) ||
                               (state_q == BUSY && cnt_q != 4'd1));
  assign OP = op_q;
  assign DR = dr_q;
  assign wb_data = wb_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dr_lat_d = dr_lat_q;
    op_d     = OP_NOP;
    dr_d     = 3'd0;
    wb_d     = wb_q;
    we       = 1'b0;
    if (state_q == BUSY) begin
      if (cnt_q == 4'd1) begin
        op_d    = OP_LD;
        dr_d    = dr_lat_q;
        wb_d    = rdata;
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (idle_act && OP_in == OP_ALU) begin
      op_d = OP_ALU;
      dr_d = DR_in;
      wb_d = ALU_res;
    end else if (idle_act && OP_in == OP_ST) begin
      we   = 1'b1;
      op_d = OP_ST;
      dr_d = DR_in;
      wb_d = ALU_res;
    end else if (idle_act && OP_in == OP_LD && MEM_LAT == 1) begin
      op_d = OP_LD;
      dr_d = DR_in;
      wb_d = rdata;
    end else if (idle_act && OP_in == OP_LD) begin
      state_d  = BUSY;
      cnt_d    = 4'(MEM_LAT - 1);
      addr_d   = in_addr;
      dr_lat_d = DR_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      dr_lat_q <= 3'd0;
      op_q     <= OP_NOP;
      dr_q     <= 3'd0;
      wb_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dr_lat_q <= dr_lat_d;
      op_q     <= op_d;
      dr_q     <= dr_d;
      wb_q     <= wb_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[in_addr] <= ST_data;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage at load latencies 1, 2 and 4 sharing one input bus.
module tb_mem_stage;
  logic        clk, rst_n, valid_in;
  logic [1:0]  OP_in;
  logic [2:0]  DR_in;
  logic [15:0] ALU_res, ST_data;
  logic        st1, st2, st4;
  logic [1:0]  op1, op2, op4;
  logic [2:0]  dr1, dr2, dr4;
  logic [15:0] wb1, wb2, wb4;
  int n_vec = 0, n_err = 0;

  mem_stage #(.ADDR_W(8), .MEM_LAT(1)) d1 (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .OP_in(OP_in),
    .DR_in(DR_in), .ALU_res(ALU_res), .ST_data(ST_data), .stall_out(st1), .OP(op1), .DR(dr1), .wb_data(wb1));
  mem_stage #(.ADDR_W(8), .MEM_LAT(2)) d2 (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .OP_in(OP_in),
    .DR_in(DR_in), .ALU_res(ALU_res), .ST_data(ST_data), .stall_out(st2), .OP(op2), .DR(dr2), .wb_data(wb2));
  mem_stage #(.ADDR_W(8), .MEM_LAT(4)) d4 (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .OP_in(OP_in),
    .DR_in(DR_in), .ALU_res(ALU_res), .ST_data(ST_data), .stall_out(st4), .OP(op4), .DR(dr4), .wb_data(wb4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] dr,
                       input logic [15:0] alu, input logic [15:0] st);
    valid_in = v; OP_in = op; DR_in = dr; ALU_res = alu; ST_data = st;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(1'b0, 2'b00, 3'd0, 16'd0, 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 2'($urandom_range(0, 3)), 3'($urandom), 16'($urandom), 16'($urandom));
      #1;
      n_vec++;
      if ({op2, dr2, wb2, st2, st4, st1} !== 24'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got OP=%b DR=%0d wb=%h stall=%b%b%b, want all zero",
                 i, op2, dr2, wb2, st1, st2, st4);
      end
    end
    @(negedge clk);
    drive(1'b0, 2'b10, 3'd1, 16'h0001, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (op2 !== 2'b00 || wb2 !== 16'd0 || st2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got OP=%b wb=%h stall=%b, want 00 0000 0", op2, wb2, st2);
    end
  endtask

  task automatic test_alu();
    pulse_reset();
    drive(1'b1, 2'b01, 3'd5, 16'hBEEF, 16'd0);
    #1;
    n_vec++;
    if (st2 !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", st2); end
    @(negedge clk);
    n_vec++;
    if (op2 !== 2'b01 || dr2 !== 3'd5 || wb2 !== 16'hBEEF) begin
      n_err++;
      $display("FAIL alu_pass: got OP=%b DR=%0d wb=%h, want 01 5 beef", op2, dr2, wb2);
    end
    drive(1'b0, 2'b01, 3'd2, 16'h1111, 16'd0);
    @(negedge clk);
    n_vec++;
    if (op2 !== 2'b00 || dr2 !== 3'd0 || wb2 !== 16'hBEEF) begin
      n_err++;
      $display("FAIL alu_bubble_hold: got OP=%b DR=%0d wb=%h, want 00 0 beef", op2, dr2, wb2);
    end
  endtask

  task automatic test_store_load();
    pulse_reset();
    drive(1'b1, 2'b11, 3'd4, 16'h0107, 16'h1234);
    #1;
    n_vec++;
    if (st2 !== 1'b0) begin n_err++; $display("FAIL store_stall: got %b want 0", st2); end
    @(negedge clk);
    n_vec++;
    if (op2 !== 2'b11 || dr2 !== 3'd4 || wb2 !== 16'h0107) begin
      n_err++;
      $display("FAIL store_out: got OP=%b DR=%0d wb=%h, want 11 4 0107", op2, dr2, wb2);
    end
    drive(1'b1, 2'b10, 3'd3, 16'h0007, 16'h0000);
    #1;
    n_vec++;
    if (st2 !== 1'b1) begin n_err++; $display("FAIL load2_stall_c0: got %b want 1", st2); end
    @(negedge clk);
    n_vec++;
    if (op2 !== 2'b00 || st2 !== 1'b0 || wb2 !== 16'h0107) begin
      n_err++;
      $display("FAIL load2_bubble: got OP=%b stall=%b wb=%h, want 00 0 0107", op2, st2, wb2);
    end
    @(negedge clk);
    n_vec++;
    if (op2 !== 2'b10 || dr2 !== 3'd3 || wb2 !== 16'h1234) begin
      n_err++;
      $display("FAIL load2_result: got OP=%b DR=%0d wb=%h, want 10 3 1234", op2, dr2, wb2);
    end
    drive(1'b0, 2'b00, 3'd0, 16'd0, 16'd0);
  endtask

  task automatic test_lat4();
    logic [3:0] exp_st = 4'b0111;
    pulse_reset();
    drive(1'b1, 2'b11, 3'd0, 16'h0020, 16'hA5A5);
    @(negedge clk);
    drive(1'b1, 2'b10, 3'd6, 16'h0020, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (st4 !== exp_st[i]) begin
        n_err++;
        $display("FAIL lat4_stall[%0d]: got %b want %b", i, st4, exp_st[i]);
      end
      @(negedge clk);
      n_vec++;
      if (i < 3 && op4 !== 2'b00) begin
        n_err++;
        $display("FAIL lat4_bubble[%0d]: got OP=%b want 00", i, op4);
      end else if (i == 3 && (op4 !== 2'b10 || dr4 !== 3'd6 || wb4 !== 16'hA5A5)) begin
        n_err++;
        $display("FAIL lat4_result: got OP=%b DR=%0d wb=%h, want 10 6 a5a5", op4, dr4, wb4);
      end
    end
    drive(1'b1, 2'b01, 3'd1, 16'h0042, 16'h0000);
    @(negedge clk);
    n_vec++;
    if (op4 !== 2'b01 || dr4 !== 3'd1 || wb4 !== 16'h0042) begin
      n_err++;
      $display("FAIL lat4_next_alu: got OP=%b DR=%0d wb=%h, want 01 1 0042", op4, dr4, wb4);
    end
    drive(1'b0, 2'b00, 3'd0, 16'd0, 16'd0);
  endtask

  task automatic test_reset_mid_load();
    pulse_reset();
    drive(1'b1, 2'b10, 3'd6, 16'h0020, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (st4 !== 1'b1) begin n_err++; $display("FAIL midrst_busy_stall: got %b want 1", st4); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (st4 !== 1'b0 || op4 !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_drop: got stall=%b OP=%b, want 0 00", st4, op4);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 3'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (op4 !== 2'b00 || st4 !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_after[%0d]: got OP=%b stall=%b, want 00 0", i, op4, st4);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    drive(1'b1, 2'b11, 3'd0, 16'h0001, 16'h0011);
    @(negedge clk);
    drive(1'b1, 2'b11, 3'd0, 16'h0002, 16'h0022);
    @(negedge clk);
    drive(1'b1, 2'b10, 3'd1, 16'h0001, 16'h0000);
    #1;
    n_vec++;
    if (st1 !== 1'b0) begin n_err++; $display("FAIL b2b_stall0: got %b want 0", st1); end
    @(negedge clk);
    n_vec++;
    if (op1 !== 2'b10 || dr1 !== 3'd1 || wb1 !== 16'h0011) begin
      n_err++;
      $display("FAIL b2b_load0: got OP=%b DR=%0d wb=%h, want 10 1 0011", op1, dr1, wb1);
    end
    drive(1'b1, 2'b10, 3'd2, 16'h0002, 16'h0000);
    #1;
    n_vec++;
    if (st1 !== 1'b0) begin n_err++; $display("FAIL b2b_stall1: got %b want 0", st1); end
    @(negedge clk);
    n_vec++;
    if (op1 !== 2'b10 || dr1 !== 3'd2 || wb1 !== 16'h0022) begin
      n_err++;
      $display("FAIL b2b_load1: got OP=%b DR=%0d wb=%h, want 10 2 0022", op1, dr1, wb1);
    end
    drive(1'b0, 2'b00, 3'd0, 16'd0, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 16'd0, 16'd0);
    test_reset();
    test_alu();
    test_store_load();
    test_lat4();
    test_reset_mid_load();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, between EX and WB.
- Owns the data memory and executes loads and stores on it.
- Holds the MEM/WB pipeline register that drives OP, DR and wb_data into the writeback stage.
- Stretches loads over a configurable latency and stalls upstream stages with stall_out while a load is in flight.

Parameters:
ADDR_W, 8, data-memory address width; memory depth is 2**ADDR_W words of 16 bits
MEM_LAT, 2, load latency in cycles; legal values are 1 to 15

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
valid_in  input  1  EX/MEM slot holds a real instruction
OP_in  input  2  00 nop, 01 ALU writeback, 10 load, 11 store
DR_in  input  3  destination register
ALU_res  input  16  ALU result; for load and store, bits [ADDR_W-1:0] are the address
ST_data  input  16  store data
stall_out  output  1  upstream holds its EX/MEM outputs unchanged while this is high
OP  output  2  registered opcode to WB; WB asserts WB_EN for 01 and 10
DR  output  3  registered destination register to WB
wb_data  output  16  registered writeback value to WB

Behaviour:
- Reset (rst_n low, asynchronous):
  - OP=00, DR=0, wb_data=0, stall_out=0.
  - FSM goes to IDLE and the load counter clears.
  - Data memory is not reset.
- FSM states: IDLE and BUSY, plus a counter cnt of width 4.
- stall_out is combinational and high when either condition holds:
  - state==IDLE, valid_in=1, OP_in=10 and MEM_LAT>1;
  - state==BUSY and cnt!=1.
- IDLE, valid_in=0 or OP_in=00: emit a bubble at the next edge.
  - Bubble means OP=00, DR=0, wb_data holds its previous value so the HEX display stays steady.
- IDLE, OP_in=01: next edge gives OP=01, DR=DR_in, wb_data=ALU_res. Latency 1.
- IDLE, OP_in=11:
  - At the edge, mem[ALU_res[ADDR_W-1:0]] <= ST_data.
  - Outputs: OP=11, DR=DR_in, wb_data=ALU_res. WB does not write back.
- IDLE, OP_in=10, MEM_LAT=1: next edge gives OP=10, DR=DR_in, wb_data=mem[addr]. No stall.
- IDLE, OP_in=10, MEM_LAT>1:
  - At the edge, latch addr and DR_in, set cnt=MEM_LAT-1, go to BUSY, emit a bubble.
- BUSY:
  - Inputs are ignored; upstream keeps them stable because stall_out is high.
  - At each edge with cnt>1: cnt decrements and a bubble is emitted.
  - At the edge with cnt==1: OP=10, DR=latched DR, wb_data=mem[latched addr], return to IDLE.
  - stall_out is low during that final BUSY cycle, so upstream advances on the same edge.
- Load timing: a load presented in cycle 0 produces its result after edge MEM_LAT. stall_out is high for cycles 0 to MEM_LAT-2.
- Address width: ALU_res bits above ADDR_W-1 are ignored, so addresses wrap modulo 2**ADDR_W.
- Read-after-write: a load following a store to the same address returns the stored data. The write is complete at the store's edge.
- Memory read is taken at the completing edge, so the address latched at acceptance is authoritative.
- rst_n asserted mid-load: the load is discarded, state goes to IDLE, stall_out drops immediately, and OP=00 (no writeback).
- A store never stalls and never overlaps a load; only one memory operation is active at a time.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> OP=00, DR=0, wb_data=0, stall_out=0. Release, send valid_in=0 -> OP stays 00.
2. ALU pass-through: OP_in=01, DR_in=5, ALU_res=16'hBEEF -> after 1 edge OP=01, DR=5, wb_data=BEEF, stall_out never high.
3. Store then load (MEM_LAT=2):
   - Store ST_data=16'h1234 at ALU_res=16'h0107 -> OP=11.
   - Then load addr 16'h0007, DR_in=3 -> stall_out=1 for 1 cycle, one bubble (OP=00), then OP=10, DR=3, wb_data=1234.
4. MEM_LAT=4, load addr 0x20 holding 16'hA5A5 -> stall_out high exactly 3 cycles, 3 bubbles, then OP=10 with A5A5. Next ALU op completes on the following edge.
5. Reset mid-load: MEM_LAT=4, assert rst_n=0 in the 2nd BUSY cycle -> stall_out=0 and OP=00 immediately. No OP=10 appears after release.
6. MEM_LAT=1, back-to-back loads from addresses 0x01 and 0x02 holding 0x0011 and 0x0022 -> stall_out stays 0, OP=10 with 0011 then 0022 on consecutive edges.
